// File: rtl/muxreg_pipe.sv
// Register pipeline with a runtime-selectable output tap: stages=0 bypasses,
// otherwise the output is taken from register stage min(stages, DEPTH).
module muxreg_pipe #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 4,
  parameter int SW    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_en,
  input  logic             flush,
  input  logic [SW-1:0]    stages,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  output logic [WIDTH-1:0] q,
  output logic             out_valid,
  output logic             busy
);

  localparam logic [SW-1:0] DEPTH_SEL = SW'(DEPTH);

  logic [WIDTH-1:0] data_reg [1:DEPTH];
  logic [DEPTH:1]   valid_reg;

  // Tap 0 is the live input; tap k is register stage k.
  logic [WIDTH-1:0] tap_data [0:DEPTH];
  logic [DEPTH:0]   tap_valid;
  logic [DEPTH:1]   in_window;
  logic [SW-1:0]    sel;

  assign sel          = (stages > DEPTH_SEL) ? DEPTH_SEL : stages;
  assign tap_data[0]  = in;
  assign tap_valid[0] = in_valid;

  genvar gi;
  generate
    for (gi = 1; gi <= DEPTH; gi++) begin : g_tap
      assign tap_data[gi]  = data_reg[gi];
      assign tap_valid[gi] = valid_reg[gi];
      assign in_window[gi] = (SW'(gi) <= sel);
    end
  endgenerate

  // Every stage shifts regardless of the tap, so deeper stages keep older data.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 1; k <= DEPTH; k++) begin
        data_reg[k] <= '0;
      end
      valid_reg <= '0;
    end else if (flush) begin
      valid_reg <= '0;
    end else if (clk_en) begin
      for (int k = 1; k <= DEPTH; k++) begin
        data_reg[k]  <= tap_data[k-1];
        valid_reg[k] <= tap_valid[k-1];
      end
    end
  end

  always_comb begin
    q         = in;
    out_valid = in_valid;
    for (int k = 0; k <= DEPTH; k++) begin
      if (sel == SW'(k)) begin
        q         = tap_data[k];
        out_valid = tap_valid[k];
      end
    end
  end

  assign busy = |(valid_reg & in_window);

endmodule

// File: doc/muxreg_pipe.md
MUXREG_PIPE -- requirements
Module: muxreg_pipe

Interface
REQ-001 Parameter WIDTH, default 18: data width in bits, legal range 1..48.
REQ-002 Parameter DEPTH, default 4: number of physical register stages, legal range 1..8.
REQ-003 Parameter SW, default 4: width of the stages port; SHALL satisfy 2^SW > DEPTH.
REQ-004 Port clk, input, 1: the single clock; all state SHALL update on its rising edge only.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port clk_en, input, 1: clock enable for the whole pipeline.
REQ-007 Port flush, input, 1: synchronous clear of valid bits only.
REQ-008 Port stages, input, SW: runtime-selected delay in cycles; 0 means combinational bypass.
REQ-009 Port in, input, WIDTH: data input.
REQ-010 Port in_valid, input, 1: qualifies in.
REQ-011 Port q, output, WIDTH: data output.
REQ-012 Port out_valid, output, 1: qualifies q.
REQ-013 Port busy, output, 1: high when any valid bit in the active stages is set.

Function
REQ-014 The block SHALL hold data registers r[1..DEPTH] and valid bits v[1..DEPTH].
REQ-015 Update priority SHALL be reset > flush > clk_en > hold.
REQ-016 When clk_en=1 and neither reset nor flush is active, the pipeline SHALL shift: r[1]<=in, v[1]<=in_valid, and r[k]<=r[k-1], v[k]<=v[k-1] for k=2..DEPTH.
REQ-017 When clk_en=0 and neither reset nor flush is active, all r and v SHALL hold their values.
REQ-018 When flush=1 and reset=0, all v SHALL clear to 0, all r SHALL hold, and no shift SHALL occur regardless of clk_en.
REQ-019 The effective delay S SHALL equal stages when stages<=DEPTH and SHALL clamp to DEPTH otherwise.
REQ-020 When S=0: q=in, out_valid=in_valid, busy=0, combinationally, with zero latency.
REQ-021 When S>0: q=r[S] and out_valid=v[S], so latency is S enabled clock edges.
REQ-022 When S>0, busy SHALL equal the OR of v[1..S].
REQ-023 A change on stages SHALL re-select the output tap combinationally in the same cycle.
REQ-024 A change on stages SHALL NOT alter, discard, or reorder the contents of r or v.
REQ-025 Registers r[S+1..DEPTH] SHALL keep shifting while stages<DEPTH, so that increasing stages later exposes older data.
REQ-026 Data in r SHALL pass through unmodified; the block performs no arithmetic, truncation, or sign extension.
REQ-027 If in_valid=1 and clk_en=0 on the same edge, the sample SHALL be dropped; the block provides no backpressure.

Reset
REQ-028 On a rising clk edge with reset=1, all r and all v SHALL become 0, irrespective of clk_en, flush, and stages.
REQ-029 After reset with S>0: q=0, out_valid=0, busy=0.
REQ-030 After reset with S=0: q and out_valid SHALL follow in and in_valid combinationally.
REQ-031 Reset asserted mid-stream SHALL discard all in-flight samples.
REQ-032 The first sample accepted after reset deasserts SHALL appear at the output after S enabled edges.
REQ-033 No output SHALL change asynchronously on a reset edge; reset takes effect only at a clk rising edge.

Verification
REQ-034 Latency sweep: DEPTH=4, WIDTH=18, clk_en=1; drive in=0x00001,0x00002,... with in_valid=1 for stages=0..4 -> q equals in delayed by exactly S cycles and out_valid tracks it; stages=0 gives q==in in the same cycle.
REQ-035 Stall: stages=3; feed A=0x11, B=0x22, C=0x33; hold clk_en=0 for 5 cycles after B enters -> q and out_valid frozen; on resume, output order is A, B, C with no duplication or loss.
REQ-036 Flush vs enable: stages=2; pipeline holds two valid samples; assert flush=1 together with clk_en=1 for one edge -> out_valid=0 and busy=0 next cycle, r unchanged (q still shows the old r[2]); the next in_valid=1 sample appears 2 enabled edges later.
REQ-037 Reset mid-operation: stages=4; pipeline full of valid data; assert reset for one edge with clk_en=1 and flush=1 -> q=0, out_valid=0, busy=0; a first post-reset sample 0x3FFFF emerges after 4 edges.
REQ-038 Tap change: stages=1 streaming 1,2,3,4,5 -> switch to stages=3 in the cycle after 5 enters -> q shows 3 immediately, with no pipeline disturbance.
REQ-039 Clamp: DEPTH=4, stages=9 -> behaviour identical to stages=4.
